// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the exhaustive truth-table sweeper.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } sweep_state_e;

    // Dwell counter width; a DWELL of 1 still needs a one-bit counter.
    function automatic int dwell_w(input int dwell);
        int w;
        w = $clog2(dwell);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tt_sweep_if.sv
// Control, status and DUT-facing signals of the truth-table sweeper.
interface tt_sweep_if #(
    parameter int N_IN = 4
);
    logic            start;
    logic            stop;
    logic            dut_out;
    logic [N_IN-1:0] stim;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_err_vec;
    logic            first_err_valid;

    modport master (
        input  start, stop, dut_out,
        output stim, busy, done, pass, err_count, first_err_vec, first_err_valid
    );

    modport slave (
        output start, stop, dut_out,
        input  stim, busy, done, pass, err_count, first_err_vec, first_err_valid
    );
endinterface

// File: rtl/tt_sweep_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled, wraps on terminal count.
module tt_sweep_dwell_timer
    import tt_sweep_pkg::*;
#(
    parameter int DWELL = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CNT_W = dwell_w(DWELL);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tc = (cnt_q == TC_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tc ? '0 : cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive sweeper: walks every input vector, holds it DWELL cycles and
// scores the DUT output against the EXPECT truth table.
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int                 N_IN   = 4,
    parameter int                 DWELL  = 10,
    parameter logic [2**N_IN-1:0] EXPECT = 16'h6996
) (
    input  logic       clk,
    input  logic       rst_n,
    tt_sweep_if.master bus
);
    localparam int              ERR_W    = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    sweep_state_e     state_q, state_d;
    logic [N_IN-1:0]  stim_q;
    logic [ERR_W-1:0] err_q;
    logic [N_IN-1:0]  fev_q;
    logic             fvalid_q;
    logic             pass_q;

    logic tc;
    logic launch;
    logic abort;
    logic sample;
    logic mismatch;
    logic last_vec;

    // A start seen on the DONE cycle chains straight into the next sweep.
    assign launch   = (state_q != APPLY) && bus.start;
    assign abort    = (state_q == APPLY) && bus.stop;
    assign sample   = (state_q == APPLY) && !bus.stop && tc;
    assign mismatch = (bus.dut_out != EXPECT[stim_q]);
    assign last_vec = (stim_q == LAST_VEC);

    tt_sweep_dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state_q != APPLY) || bus.stop),
        .en    (state_q == APPLY),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = APPLY;
            APPLY: begin
                if (bus.stop)              state_d = IDLE;
                else if (tc && last_vec)   state_d = DONE;
            end
            DONE:    state_d = bus.start ? APPLY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_q   <= '0;
            err_q    <= '0;
            fev_q    <= '0;
            fvalid_q <= 1'b0;
            pass_q   <= 1'b0;
        end else if (launch) begin
            stim_q   <= '0;
            err_q    <= '0;
            fev_q    <= '0;
            fvalid_q <= 1'b0;
            pass_q   <= 1'b0;
        end else if (abort) begin
            stim_q <= '0;
        end else if (sample) begin
            if (mismatch) begin
                err_q <= err_q + ERR_W'(1);
                if (!fvalid_q) begin
                    fev_q    <= stim_q;
                    fvalid_q <= 1'b1;
                end
            end
            // Verdict must include the final sample, which is not yet in err_q.
            if (last_vec) begin
                pass_q <= (err_q == '0) && !mismatch;
            end else begin
                stim_q <= stim_q + N_IN'(1);
            end
        end else if (state_q == DONE) begin
            stim_q <= '0;
        end
    end

    assign bus.stim            = stim_q;
    assign bus.busy            = (state_q == APPLY);
    assign bus.done            = (state_q == DONE);
    assign bus.pass            = pass_q;
    assign bus.err_count       = err_q;
    assign bus.first_err_vec   = fev_q;
    assign bus.first_err_valid = fvalid_q;
endmodule
